// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcode constants, ALU op encoding and control bundle
package decode_pkg;

    // Major opcodes of the supported RV32 subset
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    // funct3 selectors
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_MUL     = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    // funct7 selectors for R-type
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    // ALU op encoding presented to EX; NOP doubles as the bubble/illegal code
    typedef enum logic [3:0] {
        ALU_OR   = 4'h0,
        ALU_AND  = 4'h1,
        ALU_ADD  = 4'h2,
        ALU_SUB  = 4'h3,
        ALU_MUL  = 4'h4,
        ALU_ADDI = 4'h5,
        ALU_LW   = 4'h6,
        ALU_SW   = 4'h7,
        ALU_BEQ  = 4'h8,
        ALU_BNE  = 4'h9,
        ALU_NOP  = 4'hF
    } alu_op_t;

    // Datapath control bundle carried with each instruction
    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic memtoreg;
        logic alusrc;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // Formats whose rs2 field names a real source register (R, S, B)
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_BR);
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational instruction decode into op, controls and immediate
module instr_decoder
    import decode_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ENABLE_MUL = 1
) (
    input  logic [31:0]     instr,
    output alu_op_t         alu_op,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            rs2_used,
    output logic            illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign rs2_used = uses_rs2(opcode);

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    // Exact-match decode; anything unrecognised falls through as illegal with no controls
    always_comb begin
        alu_op  = ALU_NOP;
        ctrl    = CTRL_NONE;
        imm     = '0;
        rd      = 5'd0;
        illegal = 1'b1;
        case (opcode)
            OP_R: begin
                if (funct3 == F3_ADD_SUB && funct7 == F7_BASE) begin
                    alu_op = ALU_ADD;
                end else if (funct3 == F3_ADD_SUB && funct7 == F7_SUB) begin
                    alu_op = ALU_SUB;
                end else if (funct3 == F3_OR && funct7 == F7_BASE) begin
                    alu_op = ALU_OR;
                end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
                    alu_op = ALU_AND;
                end else if (funct3 == F3_MUL && funct7 == F7_MUL && ENABLE_MUL != 0) begin
                    alu_op = ALU_MUL;
                end
                if (alu_op != ALU_NOP) begin
                    illegal       = 1'b0;
                    ctrl.regwrite = 1'b1;
                    rd            = instr[11:7];
                end
            end
            OP_I: begin
                if (funct3 == F3_ADDI) begin
                    alu_op        = ALU_ADDI;
                    illegal       = 1'b0;
                    ctrl.regwrite = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    imm           = imm_i;
                    rd            = instr[11:7];
                end
            end
            OP_LW: begin
                if (funct3 == F3_LW) begin
                    alu_op        = ALU_LW;
                    illegal       = 1'b0;
                    ctrl.regwrite = 1'b1;
                    ctrl.memread  = 1'b1;
                    ctrl.memtoreg = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    imm           = imm_i;
                    rd            = instr[11:7];
                end
            end
            OP_SW: begin
                if (funct3 == F3_SW) begin
                    alu_op        = ALU_SW;
                    illegal       = 1'b0;
                    ctrl.memwrite = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    imm           = imm_s;
                end
            end
            OP_BR: begin
                if (funct3 == F3_BEQ) begin
                    alu_op  = ALU_BEQ;
                    illegal = 1'b0;
                    imm     = imm_b;
                end else if (funct3 == F3_BNE) begin
                    alu_op  = ALU_BNE;
                    illegal = 1'b0;
                    imm     = imm_b;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// rtl/decode_ctrl_stage.sv - registered ID/EX decode stage with hazard, branch and stall tracking
module decode_ctrl_stage
    import decode_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ENABLE_MUL = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      instr_i,
    input  logic             instr_valid_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic             ex_ready_i,
    output logic             valid_o,
    output logic [3:0]       alu_op_o,
    output logic             regwrite_o,
    output logic             memread_o,
    output logic             memwrite_o,
    output logic             memtoreg_o,
    output logic             alusrc_o,
    output logic [XLEN-1:0]  imm_o,
    output logic [4:0]       rd_o,
    output logic [XLEN-1:0]  rs1_val_o,
    output logic [XLEN-1:0]  rs2_val_o,
    output logic             stall_o,
    output logic             branch_taken_o,
    output logic [XLEN-1:0]  branch_target_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    alu_op_t         dec_op;
    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_rd;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic            dec_rs2_used;
    logic            dec_illegal;

    logic load_en;
    logic hz;
    logic accept;
    logic is_branch;
    logic operands_eq;
    logic take;
    logic flag_illegal;

    instr_decoder #(
        .XLEN       (XLEN),
        .ENABLE_MUL (ENABLE_MUL)
    ) u_instr_decoder (
        .instr    (instr_i),
        .alu_op   (dec_op),
        .ctrl     (dec_ctrl),
        .imm      (dec_imm),
        .rd       (dec_rd),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rs2_used (dec_rs2_used),
        .illegal  (dec_illegal)
    );

    // Handshake, load-use hazard and branch decision for the instruction now in IF/ID
    always_comb begin
        load_en      = !valid_o || ex_ready_i;
        hz           = valid_o && memread_o && (rd_o != 5'd0) && instr_valid_i &&
                       ((dec_rs1 == rd_o) || (dec_rs2_used && (dec_rs2 == rd_o)));
        stall_o      = hz || (valid_o && !ex_ready_i);
        // A taken pulse means the presented instruction is wrong-path and must not load
        accept       = load_en && !hz && !branch_taken_o && instr_valid_i && !dec_illegal;
        is_branch    = (dec_op == ALU_BEQ) || (dec_op == ALU_BNE);
        operands_eq  = (rs1_data_i == rs2_data_i);
        take         = accept && (((dec_op == ALU_BEQ) && operands_eq) ||
                                  ((dec_op == ALU_BNE) && !operands_eq));
        flag_illegal = load_en && !hz && !branch_taken_o && instr_valid_i && dec_illegal;
    end

    // ID/EX pipeline register: load decoded instruction or a bubble, hold under backpressure
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_o    <= 1'b0;
            alu_op_o   <= ALU_NOP;
            regwrite_o <= 1'b0;
            memread_o  <= 1'b0;
            memwrite_o <= 1'b0;
            memtoreg_o <= 1'b0;
            alusrc_o   <= 1'b0;
            imm_o      <= '0;
            rd_o       <= 5'd0;
            rs1_val_o  <= '0;
            rs2_val_o  <= '0;
        end else if (load_en) begin
            if (accept) begin
                valid_o    <= 1'b1;
                alu_op_o   <= dec_op;
                regwrite_o <= dec_ctrl.regwrite;
                memread_o  <= dec_ctrl.memread;
                memwrite_o <= dec_ctrl.memwrite;
                memtoreg_o <= dec_ctrl.memtoreg;
                alusrc_o   <= dec_ctrl.alusrc;
                imm_o      <= dec_imm;
                rd_o       <= dec_rd;
                rs1_val_o  <= rs1_data_i;
                rs2_val_o  <= rs2_data_i;
            end else begin
                valid_o    <= 1'b0;
                alu_op_o   <= ALU_NOP;
                regwrite_o <= 1'b0;
                memread_o  <= 1'b0;
                memwrite_o <= 1'b0;
                memtoreg_o <= 1'b0;
                alusrc_o   <= 1'b0;
                imm_o      <= '0;
                rd_o       <= 5'd0;
                rs1_val_o  <= '0;
                rs2_val_o  <= '0;
            end
        end
    end

    // Branch resolved in decode: one-cycle taken pulse plus its target
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            branch_taken_o  <= 1'b0;
            branch_target_o <= '0;
        end else begin
            branch_taken_o <= take;
            if (accept && is_branch) begin
                branch_target_o <= pc_i + dec_imm;
            end
        end
    end

    // Sticky illegal flag, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            illegal_o <= 1'b0;
        end else if (flag_illegal) begin
            illegal_o <= 1'b1;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb/tb_decode_ctrl_stage.sv - randomized and directed bench for decode_ctrl_stage
module tb_decode_ctrl_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic             rst_i;
    logic [31:0]      instr_i;
    logic             instr_valid_i;
    logic [XLEN-1:0]  pc_i;
    logic [XLEN-1:0]  rs1_data_i;
    logic [XLEN-1:0]  rs2_data_i;
    logic             ex_ready_i;

    logic             valid_o, regwrite_o, memread_o, memwrite_o, memtoreg_o, alusrc_o;
    logic [3:0]       alu_op_o;
    logic [XLEN-1:0]  imm_o, rs1_val_o, rs2_val_o, branch_target_o;
    logic [4:0]       rd_o;
    logic             stall_o, branch_taken_o, illegal_o;
    logic [CNT_W-1:0] stall_cnt_o;

    logic             n_valid, n_regwrite, n_memread, n_memwrite, n_memtoreg, n_alusrc;
    logic [3:0]       n_alu_op;
    logic [XLEN-1:0]  n_imm, n_rs1_val, n_rs2_val, n_branch_target;
    logic [4:0]       n_rd;
    logic             n_stall, n_branch_taken, n_illegal;
    logic [CNT_W-1:0] n_stall_cnt;

    decode_ctrl_stage #(.XLEN(XLEN), .ENABLE_MUL(1), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .ex_ready_i(ex_ready_i),
        .valid_o(valid_o), .alu_op_o(alu_op_o), .regwrite_o(regwrite_o), .memread_o(memread_o),
        .memwrite_o(memwrite_o), .memtoreg_o(memtoreg_o), .alusrc_o(alusrc_o), .imm_o(imm_o),
        .rd_o(rd_o), .rs1_val_o(rs1_val_o), .rs2_val_o(rs2_val_o), .stall_o(stall_o),
        .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o),
        .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
    );

    decode_ctrl_stage #(.XLEN(XLEN), .ENABLE_MUL(0), .CNT_W(CNT_W)) dut_nomul (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .ex_ready_i(ex_ready_i),
        .valid_o(n_valid), .alu_op_o(n_alu_op), .regwrite_o(n_regwrite), .memread_o(n_memread),
        .memwrite_o(n_memwrite), .memtoreg_o(n_memtoreg), .alusrc_o(n_alusrc), .imm_o(n_imm),
        .rd_o(n_rd), .rs1_val_o(n_rs1_val), .rs2_val_o(n_rs2_val), .stall_o(n_stall),
        .branch_taken_o(n_branch_taken), .branch_target_o(n_branch_target),
        .illegal_o(n_illegal), .stall_cnt_o(n_stall_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Instruction patterns: ctl = {regwrite, memread, memwrite, memtoreg, alusrc}; fmt 0=R 1=I 2=S 3=B
    typedef struct packed {
        logic [31:0] mask;
        logic [31:0] match;
        logic [3:0]  op;
        logic [4:0]  ctl;
        logic [1:0]  fmt;
    } pat_t;

    function automatic pat_t pat(input int i);
        case (i)
            0: return '{32'hFE00707F, 32'h00000033, 4'h2, 5'b10000, 2'd0};
            1: return '{32'hFE00707F, 32'h40000033, 4'h3, 5'b10000, 2'd0};
            2: return '{32'hFE00707F, 32'h00006033, 4'h0, 5'b10000, 2'd0};
            3: return '{32'hFE00707F, 32'h00007033, 4'h1, 5'b10000, 2'd0};
            4: return '{32'hFE00707F, 32'h02000033, 4'h4, 5'b10000, 2'd0};
            5: return '{32'h0000707F, 32'h00000013, 4'h5, 5'b10001, 2'd1};
            6: return '{32'h0000707F, 32'h00002003, 4'h6, 5'b11011, 2'd1};
            7: return '{32'h0000707F, 32'h00002023, 4'h7, 5'b00101, 2'd2};
            8: return '{32'h0000707F, 32'h00000063, 4'h8, 5'b00000, 2'd3};
            default: return '{32'h0000707F, 32'h00001063, 4'h9, 5'b00000, 2'd3};
        endcase
    endfunction

    typedef struct packed {
        logic        legal;
        logic [3:0]  op;
        logic [4:0]  ctl;
        logic [31:0] imm;
        logic [4:0]  rd;
    } dec_t;

    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        pat_t p;
        d = '0;
        d.op = 4'hF;
        for (int i = 0; i < 10; i++) begin
            p = pat(i);
            if ((ins & p.mask) == p.match) begin
                d.legal = 1'b1;
                d.op    = p.op;
                d.ctl   = p.ctl;
                case (p.fmt)
                    2'd1:    d.imm = {{20{ins[31]}}, ins[31:20]};
                    2'd2:    d.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                    2'd3:    d.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                    default: d.imm = 32'd0;
                endcase
                d.rd = p.ctl[4] ? ins[11:7] : 5'd0;
            end
        end
        return d;
    endfunction

    // Reference stage state
    logic        m_valid;
    logic [3:0]  m_op;
    logic [4:0]  m_ctl;
    logic [31:0] m_imm, m_v1, m_v2, m_tgt;
    logic [4:0]  m_rd;
    logic        m_bt, m_ill;
    int          m_cnt;
    logic        last_stall;

    task automatic model_reset();
        m_valid = 0; m_op = 4'hF; m_ctl = '0; m_imm = '0; m_v1 = '0; m_v2 = '0;
        m_tgt = '0; m_rd = '0; m_bt = 0; m_ill = 0; m_cnt = 0;
    endtask

    task automatic check_outputs();
        check("valid", {31'd0, valid_o}, {31'd0, m_valid});
        check("alu_op", {28'd0, alu_op_o}, {28'd0, m_op});
        check("ctrl", {27'd0, regwrite_o, memread_o, memwrite_o, memtoreg_o, alusrc_o}, {27'd0, m_ctl});
        check("imm", imm_o, m_imm);
        check("rd", {27'd0, rd_o}, {27'd0, m_rd});
        check("rs1_val", rs1_val_o, m_v1);
        check("rs2_val", rs2_val_o, m_v2);
        check("branch_taken", {31'd0, branch_taken_o}, {31'd0, m_bt});
        if (m_bt) check("branch_target", branch_target_o, m_tgt);
        check("illegal", {31'd0, illegal_o}, {31'd0, m_ill});
        check("stall_cnt", {16'd0, stall_cnt_o}, m_cnt);
    endtask

    // One clock: check combinational stall, advance the reference, check registered outputs
    task automatic step();
        logic rs2u, hz, stall, load, eq, take;
        dec_t d;
        #1;
        d    = ref_decode(instr_i);
        rs2u = (instr_i[6:0] == 7'h33) || (instr_i[6:0] == 7'h23) || (instr_i[6:0] == 7'h63);
        hz   = m_valid && m_ctl[3] && (m_rd != 0) && instr_valid_i &&
               ((instr_i[19:15] == m_rd) || (rs2u && (instr_i[24:20] == m_rd)));
        stall = hz || (m_valid && !ex_ready_i);
        load  = !m_valid || ex_ready_i;
        check("stall", {31'd0, stall_o}, {31'd0, stall});
        last_stall = stall_o;
        eq   = (rs1_data_i == rs2_data_i);
        take = 1'b0;
        if (stall && m_cnt != (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
        if (load) begin
            if (instr_valid_i && !d.legal && !hz && !m_bt) m_ill = 1'b1;
            if (hz || m_bt || !instr_valid_i || !d.legal) begin
                m_valid = 0; m_op = 4'hF; m_ctl = '0; m_imm = '0; m_rd = '0; m_v1 = '0; m_v2 = '0;
            end else begin
                m_valid = 1; m_op = d.op; m_ctl = d.ctl; m_imm = d.imm; m_rd = d.rd;
                m_v1 = rs1_data_i; m_v2 = rs2_data_i;
                if (d.op == 4'h8 || d.op == 4'h9) begin
                    m_tgt = pc_i + d.imm;
                    take  = (d.op == 4'h8) ? eq : !eq;
                end
            end
        end
        m_bt = take;
        @(posedge clk_i);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [31:0] ins;
        pat_t p;
        rst_i = 0; instr_i = 0; instr_valid_i = 0; pc_i = 0;
        rs1_data_i = 0; rs2_data_i = 0; ex_ready_i = 1;
        last_stall = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_alu_op", {28'd0, alu_op_o}, 32'hF);
        check("rst_cnt", {16'd0, stall_cnt_o}, 32'd0);
        check("rst_illegal", {31'd0, illegal_o}, 32'd0);
        rst_i = 1;

        // add x3,x1,x2
        instr_i = 32'h002081B3; instr_valid_i = 1; rs1_data_i = 5; rs2_data_i = 6;
        step();
        check("add_valid", {31'd0, valid_o}, 32'd1);
        check("add_op", {28'd0, alu_op_o}, 32'd2);
        check("add_rw", {31'd0, regwrite_o}, 32'd1);
        check("add_rd", {27'd0, rd_o}, 32'd3);
        check("add_stall", {31'd0, last_stall}, 32'd0);
        instr_valid_i = 0;
        step();

        // lw x5,0(x1) then dependent add x6,x5,x2
        instr_i = 32'h0000A283; instr_valid_i = 1;
        step();
        instr_i = 32'h00228333;
        step();
        check("lu_stall", {31'd0, last_stall}, 32'd1);
        check("lu_bubble_valid", {31'd0, valid_o}, 32'd0);
        check("lu_bubble_op", {28'd0, alu_op_o}, 32'hF);
        step();
        check("lu_add_valid", {31'd0, valid_o}, 32'd1);
        check("lu_add_rd", {27'd0, rd_o}, 32'd6);
        check("lu_cnt", {16'd0, stall_cnt_o}, 32'd1);

        // beq x1,x2,+8 at 0x100, taken then not taken
        pc_i = 32'h100; rs1_data_i = 7; rs2_data_i = 7; instr_i = 32'h00208463;
        step();
        check("beq_taken", {31'd0, branch_taken_o}, 32'd1);
        check("beq_target", branch_target_o, 32'h108);
        check("beq_rw", {31'd0, regwrite_o}, 32'd0);
        instr_i = 32'h002081B3; pc_i = 32'h104;
        step();
        check("squash_valid", {31'd0, valid_o}, 32'd0);
        check("squash_bt", {31'd0, branch_taken_o}, 32'd0);
        instr_i = 32'h00208463; pc_i = 32'h100; rs2_data_i = 8;
        step();
        check("beq_nt", {31'd0, branch_taken_o}, 32'd0);
        instr_valid_i = 0;
        step();

        // mul x3,x1,x2 with and without the multiplier
        check("nm_ill_pre", {31'd0, n_illegal}, 32'd0);
        instr_i = 32'h022081B3; instr_valid_i = 1;
        step();
        check("mul_op", {28'd0, alu_op_o}, 32'd4);
        check("nm_valid", {31'd0, n_valid}, 32'd0);
        check("nm_op", {28'd0, n_alu_op}, 32'hF);
        check("nm_ill", {31'd0, n_illegal}, 32'd1);
        instr_valid_i = 0;
        step();
        step();
        check("nm_ill_sticky", {31'd0, n_illegal}, 32'd1);

        // sw x5,4(x1) held for three cycles of backpressure
        instr_i = 32'h0050A223; instr_valid_i = 1; rs1_data_i = 32'h20; rs2_data_i = 32'h55;
        step();
        check("sw_op", {28'd0, alu_op_o}, 32'd7);
        check("sw_imm", imm_o, 32'd4);
        check("sw_mw", {31'd0, memwrite_o}, 32'd1);
        ex_ready_i = 0; instr_i = 32'h00500093;
        repeat (3) step();
        check("bp_stall", {31'd0, last_stall}, 32'd1);
        check("bp_cnt", {16'd0, stall_cnt_o}, 32'd4);
        check("bp_op", {28'd0, alu_op_o}, 32'd7);

        // Asynchronous reset in the middle of the stall
        #2;
        rst_i = 0;
        #1;
        check("arst_valid", {31'd0, valid_o}, 32'd0);
        check("arst_op", {28'd0, alu_op_o}, 32'hF);
        check("arst_cnt", {16'd0, stall_cnt_o}, 32'd0);
        check("arst_imm", imm_o, 32'd0);
        check("arst_mw", {31'd0, memwrite_o}, 32'd0);
        check("arst_stall", {31'd0, stall_o}, 32'd0);
        check("arst_nm_ill", {31'd0, n_illegal}, 32'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1; ex_ready_i = 1;

        // Randomized traffic against the reference
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) < 4) begin
                ins = $urandom;
            end else begin
                p = pat(int'($urandom_range(0, 9)));
                ins = ($urandom & ~p.mask) | p.match;
                ins[11:7]  = 5'($urandom_range(0, 3));
                ins[19:15] = 5'($urandom_range(0, 3));
                ins[24:20] = 5'($urandom_range(0, 3));
            end
            instr_i       = ins;
            instr_valid_i = ($urandom_range(0, 99) < 85);
            ex_ready_i    = ($urandom_range(0, 99) < 75);
            pc_i          = $urandom & 32'hFFFF_FFFC;
            rs1_data_i    = $urandom_range(0, 3);
            rs2_data_i    = $urandom_range(0, 3);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
- Registered ID/EX decode-and-control stage for the RV32 subset core, replacing the purely combinational opcode decoder.
- Decodes instr_i into ALU op and datapath controls, and holds them in a pipeline register with a valid/ready handshake toward EX.
- Detects load-use hazards and inserts a bubble, resolves BEQ/BNE in decode, squashes the wrong-path instruction, flags illegal instructions, and counts stall cycles.

Parameters:
- XLEN, 32, data/PC width.
- ENABLE_MUL, 1, when 0 the MUL encoding decodes as illegal.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- instr_i  in  32  instruction from IF/ID.
- instr_valid_i  in  1  instr_i is valid this cycle.
- pc_i  in  XLEN  PC of instr_i.
- rs1_data_i, rs2_data_i  in  XLEN  register-file read data.
- ex_ready_i  in  1  EX accepts the stage contents.
- valid_o  out  1  stage register holds a live instruction.
- alu_op_o  out  4  encoded op.
- regwrite_o, memread_o, memwrite_o, memtoreg_o, alusrc_o  out  1 each  datapath controls.
- imm_o  out  XLEN  sign-extended immediate.
- rd_o  out  5  destination register.
- rs1_val_o, rs2_val_o  out  XLEN  operand values.
- stall_o  out  1  combinational; IF/ID must hold.
- branch_taken_o  out  1  registered one-cycle pulse.
- branch_target_o  out  XLEN  pc_i + B-immediate, valid with the pulse.
- illegal_o  out  1  sticky illegal-instruction flag.
- stall_cnt_o  out  CNT_W  saturating count of stall_o cycles.

Behaviour:
- Op codes: OR 0, AND 1, ADD 2, SUB 3, MUL 4, ADDI 5, LW 6, SW 7, BEQ 8, BNE 9, NOP/illegal F.
- Decode requires an exact funct7/funct3/opcode match:
  - SW requires funct3=010.
  - BEQ requires funct3=000; BNE requires funct3=001.
  - Any other encoding is illegal.
- Immediates are formed by I/S/B type and sign-extended to XLEN.
- Reset (rst_i low, async):
  - valid_o, all control outputs, imm_o, rd_o, operand values, branch_taken_o, branch_target_o, illegal_o and stall_cnt_o go to 0.
  - alu_op_o goes to F.
  - Reset mid-operation discards the stage contents.
- load_en = !valid_o || ex_ready_i.
- Load-use hazard (hz): valid_o && memread_o && rd_o!=0 && rd_o matches the rs1 or rs2 field of a valid instr_i.
  - For the rs2 field, only R/S/B formats count.
- stall_o = hz || (valid_o && !ex_ready_i).
- Each edge when load_en:
  - If hz, branch_taken_o is 1, instr_valid_i is 0, or instr_i is illegal: load a bubble (valid_o=0, alu_op_o=F, all controls 0).
  - Otherwise load the decoded instruction with valid_o=1.
  - A held instruction (stall_o) is presented again on the next cycle.
- When !load_en, the register holds all values.
- Branch resolution:
  - Applies when a legal BEQ/BNE is loaded, i.e. load_en && !hz && !branch_taken_o.
  - branch_taken_o next cycle = (rs1_data_i==rs2_data_i) for BEQ, != for BNE.
  - The branch enters EX as a valid entry with regwrite_o=0.
  - The instruction presented during the taken pulse is squashed.
  - branch_taken_o is never high two consecutive cycles.
- Illegal: illegal_o sets on the first edge that loads an illegal valid instruction and holds until reset.
- stall_cnt_o increments on every edge with stall_o=1 and saturates at all-ones.
- Simultaneous hz and EX backpressure: the hazard bubble does not load until ex_ready_i; stall_o stays 1 throughout.

Decomposition:
- Shared package decode_pkg holds:
  - opcode constants (OP_R 0110011, OP_I 0010011, OP_LW 0000011, OP_SW 0100011, OP_BR 1100011);
  - funct3/funct7 constants;
  - the 4-bit ALU op enum;
  - the control-bundle struct.
- One combinational sub-module, instr_decoder: instr -> {alu_op, controls, imm, illegal}.
- The top holds the pipeline register, hazard logic, branch compare and counter.

Test Plan:
- add x3,x1,x2 (0x002081B3) valid, ex_ready_i=1 -> next cycle valid_o=1, alu_op_o=2, regwrite_o=1, rd_o=3, stall_o=0.
- lw x5,0(x1) (0x0000A283), then add x6,x5,x2 (0x00228333) -> stall_o=1 for one cycle, a bubble (valid_o=0, alu_op_o=F) issues, then add issues, stall_cnt_o=1.
- x1=x2=7, beq x1,x2,+8 (0x00208463) at pc 0x100 -> branch_taken_o pulse with target 0x108; the following instruction is squashed (valid_o=0). With x2=8 there is no pulse.
- mul x3,x1,x2 (0x022081B3) with ENABLE_MUL=0 -> a bubble loads and illegal_o=1 and stays 1. With ENABLE_MUL=1 -> alu_op_o=4.
- sw x5,4(x1) (0x0050A223) with ex_ready_i=0 for 3 cycles -> outputs held, stall_o=1, stall_cnt_o +3; alu_op_o=7, imm_o=4, memwrite_o=1.
- rst_i low mid-stall -> all outputs are reset immediately without a clock edge and stall_cnt_o=0.
